dmem_uart: RTL

Data-side memory subsystem for the single-cycle RV32I core. It sits directly downstream of the core's data port and consumes `MemWrite`, `ALUResult` (byte address) and `WriteData`, and returns `ReadData` in the same cycle. It holds a word-addressed data RAM plus a memory-mapped UART transmitter with a small TX FIFO, so that programs can emit characters.

---
 rtl/dmem_uart.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dmem_uart.sv
// Data memory for the single-cycle RV32I core with a memory-mapped UART TX.
// Word RAM at bit31=0; UART DATA/STATUS at 0x8000_0000/0x8000_0004.
module dmem_uart #(
  parameter int RAM_WORDS    = 64,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [FW:0] CNT_FULL = (FW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [AW-1:0] idx;
  logic          sel_ram, sel_data, sel_stat;
  logic          unused_lsb;

  assign idx        = ALUResult[AW+1:2];
  assign sel_ram    = ~ALUResult[31];
  assign sel_data   = ALUResult[31:2] == 30'h2000_0000;
  assign sel_stat   = ALUResult[31:2] == 30'h2000_0001;
  assign unused_lsb = ^ALUResult[1:0];

  logic [31:0] mem_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (MemWrite && sel_ram) mem_q[idx] <= WriteData;
  end

  logic [7:0]  fifo_q [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FW:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        empty, full, push, pop;

  assign empty = cnt_q == '0;
  assign full  = cnt_q == CNT_FULL;
  // full is the pre-edge value, so a same-edge pop never rescues a push
  assign push  = MemWrite && sel_data && !full;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= WriteData[7:0];
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    ovf_d = ovf_q;
    if (MemWrite && sel_stat) ovf_d = 1'b0;
    else if (MemWrite && sel_data && full) ovf_d = 1'b1;
  end

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_done;

  assign baud_done = baud_q == BAUD_LAST;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          bit_d   = '0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        baud_d = baud_q + 1'b1;
        if (baud_done) begin
          baud_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + 1'b1;
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        baud_d = baud_q + 1'b1;
        if (baud_done) begin
          baud_d  = '0;
          state_d = IDLE;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_q[rd_ptr_q];
            bit_d   = '0;
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // tx is registered from the next state so the line never glitches
    tx_d = 1'b1;
    if (state_d == START) tx_d = 1'b0;
    else if (state_d == DATA) tx_d = shift_d[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = state_q != IDLE;

  always_comb begin
    ReadData = '0;
    unique case (1'b1)
      sel_ram:  ReadData = mem_q[idx];
      sel_stat: ReadData = {28'b0, ovf_q, tx_busy, full, empty};
      default:  ReadData = '0;
    endcase
  end

endmodule
